data_mem_port: RTL and testbench
================================

# data_mem_port

Parametrised data memory with a valid/ready request port, byte/half/word access, sign/zero-extended loads, configurable access latency and fault reporting. It replaces the plain combinational-read word RAM in the multi-cycle core. The core's memory stage issues one request, stalls until `resp_valid`, then consumes `resp_rdata`/`resp_fault`.

## Interface
- `DEPTH`, 8192: number of 32-bit words; word index = `req_addr[31:2]`.
- `LATENCY`, 1: cycles from the accept edge to the commit edge; legal range 1..15.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block accepts a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: the request was misaligned, illegal or out of range.

## Operation
- FSM states: IDLE, BUSY, RESP. `req_ready` = (state==IDLE) && !reset.
- Accept: IDLE && `req_valid`. On that edge, latch write, addr, size, unsigned and wdata; load the counter with LATENCY-1; go to BUSY.
- BUSY with counter != 0: decrement. BUSY with counter == 0: commit the access, register the response, go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. No response backpressure.
- Fault rule: size==11; or half with addr[0]=1; or word with addr[1:0]!=0; or addr[31:2] >= DEPTH. On a fault the store is suppressed, `resp_rdata`=0 and `resp_fault`=1.
- Store byte enables:
  - byte: bit addr[1:0] only.
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - word: 1111.
  - Data is replicated across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}.
  - Lanes that are not enabled keep their old contents.
- Load extraction:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - The selected value is extended to 32 bits by sign or zero, per `req_unsigned`.
- Memory contents are not reset and not initialised (X in simulation unless preloaded).

## Timing
- Request accepted at edge 0 → commit at edge LATENCY → `resp_valid` high in the cycle after edge LATENCY.
- Back-to-back requests: one per LATENCY+2 cycles.
- `resp_rdata`/`resp_fault` are registered at the commit edge and hold until the next commit.
- Request inputs are ignored outside the accept cycle; they may change freely in BUSY and RESP.
- Reset values: state IDLE, counter 0, `resp_valid` 0, `resp_rdata` 0, `resp_fault` 0, `req_ready` 0 while reset is high.
- Reset asserted in BUSY before the commit edge: the store is dropped and no response is produced.
- Reset asserted in RESP: the pulse is cut immediately.
- A load reads memory as it stands before the commit edge; a store's new value is visible to any later request.

## Structure
- Package `mem_pkg`:
  - size codes `SIZE_B`/`SIZE_H`/`SIZE_W`.
  - state enum.
  - function `byte_en(size, addr_lo)` returning 4 bits.
  - function `load_extend(word, size, addr_lo, unsigned)`.
- Sub-module `mem_array`: DEPTH×32 storage with a 4-bit byte-write enable and a read port sampled at the commit edge.
- `data_mem_port` contains the FSM, counter, fault check and lane logic. `mem_array` is the only storage.

## Test plan
- LATENCY=1, store word 0xDEADBEEF at 0x100, then load word at 0x100 → `resp_valid` 2 cycles after each accept; rdata 0xDEADBEEF; fault 0.
- Store byte 0x80 at 0x101 over 0x11223344, then:
  - signed byte load at 0x101 → 0xFFFFFF80.
  - unsigned byte load at 0x101 → 0x00000080.
  - word load at 0x100 → 0x11228044.
- Half store 0xABCD at 0x202 over 0, then signed half load at 0x202 → 0xFFFFABCD; word load at 0x200 → 0xABCD0000.
- Faults, each with old data unchanged:
  - half load at 0x103 → fault 1, rdata 0.
  - word store at 0x102 → fault 1.
  - word load at DEPTH*4 → fault 1.
  - size=11 → fault 1.
- LATENCY=4 with `req_valid` held high → accepts spaced 6 cycles apart; `req_ready` low in BUSY/RESP; exactly one `resp_valid` per request.
- Assert reset 2 cycles after accepting a store (LATENCY=4) → no `resp_valid`; later load of that word returns the pre-store value; outputs are 0 during reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data memory port.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] en;
    case (size)
      SIZE_B:  en = 4'b0001 << addr_lo;
      SIZE_H:  en = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr_lo, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*addr_lo +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  r = {{24{~is_unsigned & b[7]}}, b};
      SIZE_H:  r = {{16{~is_unsigned & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_port_mem_array.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
module mem_array #(
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned AW    = 13
) (
  input  logic          clock,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_port.sv
// Valid/ready data memory port: latency counter FSM, fault checks and lane steering.
module data_mem_port
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 8192,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        write_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic        accept, commit, fault, align_err, range_err;
  logic [3:0]  we;
  logic [31:0] wdata_lanes, rdata_raw;

  assign accept = (state_q == IDLE) && req_valid;
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    align_err = 1'b0;
    case (size_q)
      SIZE_B:  align_err = 1'b0;
      SIZE_H:  align_err = addr_q[0];
      SIZE_W:  align_err = (addr_q[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
  end

  assign range_err = (32'(addr_q[31:2]) >= DEPTH);
  assign fault     = align_err || range_err;

  always_comb begin
    case (size_q)
      SIZE_B:  wdata_lanes = {4{wdata_q[7:0]}};
      SIZE_H:  wdata_lanes = {2{wdata_q[15:0]}};
      default: wdata_lanes = wdata_q;
    endcase
  end

  // Faulted or non-committing cycles must never touch the array.
  assign we = (commit && write_q && !fault) ? byte_en(size_q, addr_q[1:0]) : '0;

  mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clock(clock),
    .we   (we),
    .addr (addr_q[AW+1:2]),
    .wdata(wdata_lanes),
    .rdata(rdata_raw)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        cnt_q   <= 4'(LATENCY - 1);
      end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        resp_rdata <= (fault || write_q) ? '0 : load_extend(rdata_raw, size_q, addr_q[1:0], uns_q);
        resp_fault <= fault;
      end
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port at LATENCY=1 and LATENCY=4.
module tb_data_mem_port;

  logic        clock = 1'b0;
  logic        rst1, rst4, valid1, valid4;
  logic        req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        ready1, ready4, rv1, rv4, fault1, fault4;
  logic [31:0] rdata1, rdata4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_mem_port #(.DEPTH(8192), .LATENCY(1)) dut1 (
    .clock(clock), .reset(rst1), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rdata1), .resp_fault(fault1)
  );

  data_mem_port #(.DEPTH(8192), .LATENCY(4)) dut4 (
    .clock(clock), .reset(rst4), .req_valid(valid4), .req_ready(ready4),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv4), .resp_rdata(rdata4), .resp_fault(fault4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction; returns response data, fault and negedges from accept to resp_valid.
  task automatic req(input bit sel, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                     input bit uns, input logic [31:0] wd,
                     output logic [31:0] rd, output logic flt, output int lat);
    int n;
    @(negedge clock);
    req_write = wr; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
    if (sel) valid4 = 1'b1; else valid1 = 1'b1;
    n = 0;
    while (!(sel ? ready4 : ready1) && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 valid1 = 1'b0; valid4 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (sel ? rv4 : rv1) break;
    end
    if (!(sel ? rv4 : rv1)) check("resp_timeout", 32'd0, 32'd1);
    rd  = sel ? rdata4 : rdata1;
    flt = sel ? fault4 : fault1;
    @(negedge clock);
    check("pulse_len", 32'(sel ? rv4 : rv1), 32'd0);
  endtask

  logic [31:0] rd;
  logic        flt;
  int          lat;
  int          acc[$];
  int          nready, nresp;

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(ready1), 32'd0);
    check("rst_valid", 32'(rv1), 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_fault", 32'(fault1), 32'd0);
    rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clock);
    check("idle_ready", 32'(ready1), 32'd1);

    req(0, 1, 32'h100, 2'b10, 0, 32'hDEADBEEF, rd, flt, lat);
    check("st_lat", 32'(lat), 32'd2);
    check("st_fault", 32'(flt), 32'd0);
    check("st_rdata", rd, 32'd0);
    req(0, 0, 32'h100, 2'b10, 0, 32'h0, rd, flt, lat);
    check("ld_lat", 32'(lat), 32'd2);
    check("ld_word", rd, 32'hDEADBEEF);
    check("ld_fault", 32'(flt), 32'd0);

    req(0, 1, 32'h100, 2'b10, 0, 32'h11223344, rd, flt, lat);
    req(0, 1, 32'h101, 2'b00, 0, 32'h00000080, rd, flt, lat);
    req(0, 0, 32'h101, 2'b00, 0, 32'h0, rd, flt, lat);
    check("lb_signed", rd, 32'hFFFFFF80);
    req(0, 0, 32'h101, 2'b00, 1, 32'h0, rd, flt, lat);
    check("lb_unsigned", rd, 32'h00000080);
    req(0, 0, 32'h100, 2'b10, 0, 32'h0, rd, flt, lat);
    check("lw_after_sb", rd, 32'h11228044);

    req(0, 1, 32'h200, 2'b10, 0, 32'h0, rd, flt, lat);
    req(0, 1, 32'h202, 2'b01, 0, 32'h0000ABCD, rd, flt, lat);
    req(0, 0, 32'h202, 2'b01, 0, 32'h0, rd, flt, lat);
    check("lh_signed", rd, 32'hFFFFABCD);
    req(0, 0, 32'h202, 2'b01, 1, 32'h0, rd, flt, lat);
    check("lh_unsigned", rd, 32'h0000ABCD);
    req(0, 0, 32'h200, 2'b10, 0, 32'h0, rd, flt, lat);
    check("lw_after_sh", rd, 32'hABCD0000);

    req(0, 0, 32'h103, 2'b01, 0, 32'h0, rd, flt, lat);
    check("f_lh_mis_fault", 32'(flt), 32'd1);
    check("f_lh_mis_rdata", rd, 32'd0);
    req(0, 1, 32'h102, 2'b10, 0, 32'hCAFEF00D, rd, flt, lat);
    check("f_sw_mis_fault", 32'(flt), 32'd1);
    req(0, 0, 32'h8000, 2'b10, 0, 32'h0, rd, flt, lat);
    check("f_lw_oor_fault", 32'(flt), 32'd1);
    check("f_lw_oor_rdata", rd, 32'd0);
    req(0, 1, 32'h8100, 2'b10, 0, 32'hBAD0BAD0, rd, flt, lat);
    check("f_sw_oor_fault", 32'(flt), 32'd1);
    req(0, 0, 32'h100, 2'b11, 0, 32'h0, rd, flt, lat);
    check("f_size3_ld_fault", 32'(flt), 32'd1);
    check("f_size3_ld_rdata", rd, 32'd0);
    req(0, 1, 32'h100, 2'b11, 0, 32'hFFFFFFFF, rd, flt, lat);
    check("f_size3_st_fault", 32'(flt), 32'd1);
    req(0, 0, 32'h100, 2'b10, 0, 32'h0, rd, flt, lat);
    check("f_word_intact", rd, 32'h11228044);
    check("f_clear_fault", 32'(flt), 32'd0);

    req(1, 1, 32'h40, 2'b10, 0, 32'h55AA55AA, rd, flt, lat);
    check("l4_st_lat", 32'(lat), 32'd5);
    req(1, 0, 32'h40, 2'b10, 0, 32'h0, rd, flt, lat);
    check("l4_ld_lat", 32'(lat), 32'd5);
    check("l4_ld_word", rd, 32'h55AA55AA);

    // Back-to-back: valid held high, ready sampled each negedge.
    req_write = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clock);
    #1 valid4 = 1'b1;
    nready = 0; nresp = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      if (ready4) begin
        nready++;
        acc.push_back(i);
      end
      if (rv4) nresp++;
    end
    valid4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (rv4) nresp++;
    end
    check("b2b_accepts", 32'(nready), 32'd5);
    check("b2b_first", 32'(acc.size() > 0 ? acc[0] : -1), 32'd0);
    for (int k = 1; k < acc.size(); k++) check("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'd6);
    check("b2b_resps", 32'(nresp), 32'd5);

    // Store interrupted by reset two cycles after accept.
    @(negedge clock);
    req_write = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'h12345678;
    valid4 = 1'b1;
    check("abort_ready", 32'(ready4), 32'd1);
    @(posedge clock);
    #1 valid4 = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 rst4 = 1'b1;
    nresp = 0;
    repeat (2) begin
      @(negedge clock);
      if (rv4) nresp++;
    end
    check("abort_rst_ready", 32'(ready4), 32'd0);
    check("abort_rst_rdata", rdata4, 32'd0);
    check("abort_rst_fault", 32'(fault4), 32'd0);
    rst4 = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (rv4) nresp++;
    end
    check("abort_no_resp", 32'(nresp), 32'd0);
    req(1, 0, 32'h40, 2'b10, 0, 32'h0, rd, flt, lat);
    check("abort_word_old", rd, 32'h55AA55AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
